// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece sequencer: playfield defaults, FSM states and 4x4 shape tables.
package tetris_pkg;

  localparam int AREA_ROW_DEF    = 32;
  localparam int AREA_COL_DEF    = 16;
  localparam int ROW_ADDR_W_DEF  = 5;
  localparam int COL_ADDR_W_DEF  = 4;
  localparam int GRAVITY_DIV_DEF = 50000;
  localparam int SPAWN_COL_DEF   = 6;
  localparam int NUM_PIECES      = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_FALL,
    ST_UPDATE,
    ST_OVER
  } fall_state_e;

  // Piece order O I T S Z J L; masks row-major, bit15 top-left, each rotation packed to the top-left.
  localparam logic [15:0] SHAPE [NUM_PIECES][4] = '{
    '{16'hCC00, 16'hCC00, 16'hCC00, 16'hCC00},
    '{16'hF000, 16'h8888, 16'hF000, 16'h8888},
    '{16'hE400, 16'h4C40, 16'h4E00, 16'h8C80},
    '{16'h6C00, 16'h8C40, 16'h6C00, 16'h8C40},
    '{16'hC600, 16'h4C80, 16'hC600, 16'h4C80},
    '{16'h8E00, 16'hC880, 16'hE200, 16'h44C0},
    '{16'h2E00, 16'h88C0, 16'hE800, 16'hC440}
  };

  localparam logic [2:0] SHAPE_W [NUM_PIECES][4] = '{
    '{3'd2, 3'd2, 3'd2, 3'd2},
    '{3'd4, 3'd1, 3'd4, 3'd1},
    '{3'd3, 3'd2, 3'd3, 3'd2},
    '{3'd3, 3'd2, 3'd3, 3'd2},
    '{3'd3, 3'd2, 3'd3, 3'd2},
    '{3'd3, 3'd2, 3'd3, 3'd2},
    '{3'd3, 3'd2, 3'd3, 3'd2}
  };

  localparam logic [2:0] SHAPE_H [NUM_PIECES][4] = '{
    '{3'd2, 3'd2, 3'd2, 3'd2},
    '{3'd1, 3'd4, 3'd1, 3'd4},
    '{3'd2, 3'd3, 3'd2, 3'd3},
    '{3'd2, 3'd3, 3'd2, 3'd3},
    '{3'd2, 3'd3, 3'd2, 3'd3},
    '{3'd2, 3'd3, 3'd2, 3'd3},
    '{3'd2, 3'd3, 3'd2, 3'd3}
  };

endpackage

// File: rtl/tetris_shape_rom.sv
// Combinational shape lookup: (piece_id, rot) -> 4x4 mask plus occupied width and height.
module tetris_shape_rom
  import tetris_pkg::*;
(
  input  logic [2:0]  piece_id,
  input  logic [1:0]  rot,
  output logic [15:0] mask,
  output logic [2:0]  width,
  output logic [2:0]  height
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    mask   = '0;
    width  = '0;
    height = '0;
    if (piece_id < 3'(NUM_PIECES)) begin
      mask   = SHAPE[piece_id][rot];
      width  = SHAPE_W[piece_id][rot];
      height = SHAPE_H[piece_id][rot];
    end
  end

endmodule

// File: rtl/tetris_fall_ctrl.sv
// Falling-piece sequencer: spawn, gravity timer, step strobes and wall-checked moves.
// Optional hard drop is compiled in with `define HARD_DROP_EN.
module tetris_fall_ctrl
  import tetris_pkg::*;
#(
  parameter int AREA_ROW    = AREA_ROW_DEF,
  parameter int AREA_COL    = AREA_COL_DEF,
  parameter int ROW_ADDR_W  = ROW_ADDR_W_DEF,
  parameter int COL_ADDR_W  = COL_ADDR_W_DEF,
  parameter int GRAVITY_DIV = GRAVITY_DIV_DEF,
  parameter int SPAWN_COL   = SPAWN_COL_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_rot,
  input  logic                  btn_drop,
  input  logic                  mv_down_enable,
  input  logic                  game_over,
  output logic                  falling_update,
  output logic [ROW_ADDR_W-1:0] mv_blk_row,
  output logic [COL_ADDR_W-1:0] mv_blk_col,
  output logic [15:0]           mv_blk_data,
  output logic [2:0]            piece_id
);

  localparam int CNT_W = $clog2(GRAVITY_DIV);
  localparam int CW1   = COL_ADDR_W + 1;
  localparam int RW1   = ROW_ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAVITY_DIV - 1);

  fall_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ROW_ADDR_W-1:0] row_q;
  logic [COL_ADDR_W-1:0] col_q;
  logic [1:0]            rot_q, rot_nxt;
  logic [2:0]            pid_q, lfsr_q;
  logic                  fu_q;
  logic [15:0]           cur_mask, unused_nxt_mask;
  logic [2:0]            cur_w, nxt_w, nxt_h, unused_cur_h;
  logic                  drop_q, abort, tick, move_ok, rot_fits;
  logic                  do_rot, do_left, do_right;

  assign rot_nxt = rot_q + 2'd1;

  tetris_shape_rom u_rom_cur (
    .piece_id (pid_q),
    .rot      (rot_q),
    .mask     (cur_mask),
    .width    (cur_w),
    .height   (unused_cur_h)
  );

  tetris_shape_rom u_rom_nxt (
    .piece_id (pid_q),
    .rot      (rot_nxt),
    .mask     (unused_nxt_mask),
    .width    (nxt_w),
    .height   (nxt_h)
  );

`ifdef HARD_DROP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_q <= 1'b0;
    end else if (state_q == ST_SPAWN || state_q == ST_OVER || state_d == ST_OVER) begin
      drop_q <= 1'b0;
    end else if (state_q == ST_FALL && btn_drop) begin
      drop_q <= 1'b1;
    end
  end
`else
  logic unused_btn_drop;
  assign unused_btn_drop = btn_drop;
  assign drop_q          = 1'b0;
`endif

  // game_over outranks everything once play has started; a drop flag forces a tick every FALL cycle.
  assign abort   = game_over && (state_q != ST_IDLE);
  assign tick    = (state_q == ST_FALL) && (drop_q || cnt_q == CNT_LAST);
  assign move_ok = (state_q == ST_FALL) && !tick && !abort;

  assign rot_fits = (CW1'(col_q) + CW1'(nxt_w) <= CW1'(AREA_COL)) &&
                    (RW1'(row_q) + RW1'(nxt_h) <= RW1'(AREA_ROW));

  assign do_rot   = move_ok && btn_rot && rot_fits;
  assign do_left  = move_ok && !btn_rot && btn_left && !btn_right && (col_q != '0);
  assign do_right = move_ok && !btn_rot && btn_right && !btn_left &&
                    (CW1'(col_q) + CW1'(cur_w) < CW1'(AREA_COL));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SPAWN;
      ST_SPAWN:  state_d = ST_FALL;
      ST_FALL:   if (tick) state_d = ST_UPDATE;
      ST_UPDATE: state_d = mv_down_enable ? ST_FALL : ST_SPAWN;
      ST_OVER:   state_d = ST_OVER;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_OVER;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= 3'b001;
      fu_q   <= 1'b0;
      cnt_q  <= '0;
      row_q  <= '0;
      col_q  <= COL_ADDR_W'(SPAWN_COL);
      rot_q  <= '0;
      pid_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
      fu_q   <= (state_d == ST_UPDATE);
      if (!abort) begin
        case (state_q)
          ST_SPAWN: begin
            row_q <= '0;
            col_q <= COL_ADDR_W'(SPAWN_COL);
            rot_q <= '0;
            pid_q <= lfsr_q - 3'd1;
            cnt_q <= '0;
          end
          ST_FALL: begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (do_rot)        rot_q <= rot_nxt;
            else if (do_left)  col_q <= col_q - 1'b1;
            else if (do_right) col_q <= col_q + 1'b1;
          end
          ST_UPDATE: if (mv_down_enable) row_q <= row_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign falling_update = fu_q;
  assign mv_blk_row     = row_q;
  assign mv_blk_col     = col_q;
  assign mv_blk_data    = cur_mask;
  assign piece_id       = pid_q;

endmodule

// File: tb/tb_tetris_fall_ctrl.sv
// Self-checking bench for tetris_fall_ctrl with a fast gravity tick (GRAVITY_DIV=4).
module tb_tetris_fall_ctrl;

  localparam int GDIV = 4;
  // LFSR value after k clocks out of reset is SEQ[k % 7]; spawn-orientation masks by piece id.
  localparam int SEQ [7] = '{1, 2, 5, 3, 7, 6, 4};
  localparam logic [15:0] ROT0 [7] = '{16'hCC00, 16'hF000, 16'hE400, 16'h6C00,
                                      16'hC600, 16'h8E00, 16'h2E00};

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_drop = 1'b0;
  logic        mv_down_enable = 1'b1, game_over = 1'b0;
  logic        falling_update;
  logic [4:0]  mv_blk_row;
  logic [3:0]  mv_blk_col;
  logic [15:0] mv_blk_data;
  logic [2:0]  piece_id;

  typedef struct {logic l; logic r; logic ro; logic [3:0] col; logic [15:0] data;} vec_t;
  typedef struct {string name; logic [3:0] col; logic [15:0] data;} exp_t;

  vec_t o_vecs[$];
  vec_t i_vecs[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int since_fu = 99;
  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  tetris_fall_ctrl #(.GRAVITY_DIV(GDIV)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_rot        (btn_rot),
    .btn_drop       (btn_drop),
    .mv_down_enable (mv_down_enable),
    .game_over      (game_over),
    .falling_update (falling_update),
    .mv_blk_row     (mv_blk_row),
    .mv_blk_col     (mv_blk_col),
    .mv_blk_data    (mv_blk_data),
    .piece_id       (piece_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no DUT event within cycle budget", name);
  endtask

  task automatic tick();
    @(negedge clk);
    if (falling_update) since_fu = 0;
    else if (since_fu < 99) since_fu++;
  endtask

  task automatic wait_fu(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!falling_update && n < 20);
    if (!falling_update) timeout(name);
  endtask

  // A move slot is one of the FALL cycles before the gravity tick.
  task automatic wait_slot();
    int guard = 0;
    while (!(since_fu >= 1 && since_fu <= GDIV - 1) && guard < 20) begin
      tick();
      guard++;
    end
    if (!(since_fu >= 1 && since_fu <= GDIV - 1)) timeout("wait_slot");
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      timeout("scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    check({e.name, "_col"}, 32'(mv_blk_col), 32'(e.col));
    check({e.name, "_mask"}, 32'(mv_blk_data), 32'(e.data));
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    exp_t e;
    wait_slot();
    btn_left  = v.l;
    btn_right = v.r;
    btn_rot   = v.ro;
    e.name = nm;
    e.col  = v.col;
    e.data = v.data;
    sb.push_back(e);
    tick();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_rot   = 1'b0;
    sb_compare();
  endtask

  task automatic do_reset();
    btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_drop = 1'b0;
    start = 1'b0; game_over = 1'b0; mv_down_enable = 1'b1;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    since_fu = 99;
  endtask

  // Times the start pulse so the spawned piece is `target`; leaves the bench at the first FALL cycle.
  task automatic start_piece(input int target);
    int guard = 0;
    int exp_pid;
    while (SEQ[(cyc + 1) % 7] != target + 1 && guard < 10) begin
      tick();
      guard++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pid = SEQ[cyc % 7] - 1;
    tick();
    check("spawn_pid", 32'(piece_id), 32'(exp_pid));
    check("spawn_row", 32'(mv_blk_row), 32'd0);
    check("spawn_col", 32'(mv_blk_col), 32'd6);
    check("spawn_mask", 32'(mv_blk_data), 32'(ROT0[exp_pid]));
    since_fu = 99;
  endtask

  function automatic vec_t mk(input logic l, input logic r, input logic ro,
                              input int col, input logic [15:0] data);
    vec_t v;
    v.l = l; v.r = r; v.ro = ro; v.col = 4'(col); v.data = data;
    return v;
  endfunction

  initial begin : main
    int n;
    int exp_pid;

    // O piece walks into both walls; I piece exercises rotation against the right wall.
    for (int i = 0; i < 7; i++)  o_vecs.push_back(mk(1'b1, 1'b0, 1'b0, (5 - i < 0) ? 0 : 5 - i, 16'hCC00));
    for (int i = 0; i < 15; i++) o_vecs.push_back(mk(1'b0, 1'b1, 1'b0, (i + 1 > 14) ? 14 : i + 1, 16'hCC00));
    i_vecs.push_back(mk(1'b0, 1'b0, 1'b1, 6, 16'h8888));
    for (int i = 0; i < 10; i++) i_vecs.push_back(mk(1'b0, 1'b1, 1'b0, (7 + i > 15) ? 15 : 7 + i, 16'h8888));
    i_vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15, 16'h8888));
    for (int i = 0; i < 3; i++)  i_vecs.push_back(mk(1'b1, 1'b0, 1'b0, 14 - i, 16'h8888));
    i_vecs.push_back(mk(1'b0, 1'b0, 1'b1, 12, 16'hF000));
    i_vecs.push_back(mk(1'b1, 1'b0, 1'b1, 12, 16'h8888));
    i_vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12, 16'h8888));

    // Reset values
    tick();
    check("rst_fu", 32'(falling_update), 32'd0);
    check("rst_row", 32'(mv_blk_row), 32'd0);
    check("rst_col", 32'(mv_blk_col), 32'd6);
    check("rst_pid", 32'(piece_id), 32'd0);
    check("rst_mask", 32'(mv_blk_data), 32'hCC00);
    rstn = 1'b1;
    tick();

    // Gravity cadence and row stepping, then lock at row 9
    start_piece(3);
    wait_fu("first_update", n);
    check("first_update_gap", 32'(n), 32'd4);
    check("update_row_0", 32'(mv_blk_row), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      wait_fu("update", n);
      check($sformatf("update_gap_%0d", k), 32'(n), 32'd5);
      check($sformatf("update_row_%0d", k), 32'(mv_blk_row), 32'(k));
    end
    mv_down_enable = 1'b0;
    tick();
    check("lock_spawn_fu", 32'(falling_update), 32'd0);
    exp_pid = SEQ[cyc % 7] - 1;
    mv_down_enable = 1'b1;
    tick();
    check("respawn_row", 32'(mv_blk_row), 32'd0);
    check("respawn_col", 32'(mv_blk_col), 32'd6);
    check("respawn_pid", 32'(piece_id), 32'(exp_pid));
    check("respawn_mask", 32'(mv_blk_data), 32'(ROT0[exp_pid]));

    // O piece against both walls
    do_reset();
    start_piece(0);
    foreach (o_vecs[i]) apply_vec(o_vecs[i], $sformatf("o_move_%0d", i));

    // I piece rotation at the wall, priority and simultaneous buttons
    do_reset();
    start_piece(1);
    foreach (i_vecs[i]) apply_vec(i_vecs[i], $sformatf("i_move_%0d", i));

    // A button on the gravity-tick cycle is dropped
    n = 0;
    while (since_fu != GDIV && n < 20) begin
      tick();
      n++;
    end
    if (since_fu != GDIV) timeout("tick_slot");
    btn_left = 1'b1;
    sb.push_back('{"tick_drop", 4'd12, 16'h8888});
    tick();
    btn_left = 1'b0;
    check("tick_drop_fu", 32'(falling_update), 32'd1);
    sb_compare();

    // game_over mid-FALL: OVER is sticky and deaf to buttons
    wait_slot();
    game_over = 1'b1;
    tick();
    check("over_fu", 32'(falling_update), 32'd0);
    for (int i = 0; i < 12; i++) begin
      btn_left  = (i % 3 == 0);
      btn_right = (i % 3 == 1);
      btn_rot   = (i % 3 == 2);
      tick();
      check($sformatf("over_fu_%0d", i), 32'(falling_update), 32'd0);
      check($sformatf("over_col_%0d", i), 32'(mv_blk_col), 32'd12);
      check($sformatf("over_mask_%0d", i), 32'(mv_blk_data), 32'h8888);
    end
    btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0;
    game_over = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("over_hold_fu_%0d", i), 32'(falling_update), 32'd0);
    end

    // Asynchronous reset in the middle of UPDATE
    do_reset();
    start_piece(2);
    wait_fu("pre_reset_update", n);
    rstn = 1'b0;
    #1;
    check("async_rst_fu", 32'(falling_update), 32'd0);
    check("async_rst_row", 32'(mv_blk_row), 32'd0);
    check("async_rst_col", 32'(mv_blk_col), 32'd6);
    check("async_rst_pid", 32'(piece_id), 32'd0);
    check("async_rst_mask", 32'(mv_blk_data), 32'hCC00);
    tick();
    rstn = 1'b1;
    tick();

`ifdef HARD_DROP_EN
    // Hard drop: a step every other cycle until the piece locks, normal cadence afterwards
    do_reset();
    start_piece(0);
    wait_slot();
    btn_drop = 1'b1;
    tick();
    btn_drop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("drop_fu_%0d", i), 32'(falling_update), 32'(i % 2));
    end
    mv_down_enable = 1'b0;
    tick();
    mv_down_enable = 1'b1;
    check("drop_lock_fu", 32'(falling_update), 32'd0);
    wait_fu("post_drop_update", n);
    check("post_drop_gap", 32'(n), 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
